mpnc_mshr_file: RTL

//  Parametrised in-order MSHR file for the non-blocking multi-port D-cache (successor to the fixed 2-port MSHR).

---
 rtl/mpnc_mshr_file.sv | 260 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/mpnc_mshr_file.sv
// In-order MSHR file for the multi-port non-blocking D-cache. It merges secondary misses,
// issues one line read at a time, and presents each fill with its buffered stores overlaid.

module mpnc_mshr_port_dec #(
    parameter int ADDR_WIDTH = 16,
    parameter int LINE_BITS  = 256,
    parameter int WORD_BITS  = 16,
    localparam int LB   = LINE_BITS / 8,
    localparam int OFF  = $clog2(LB),
    localparam int WB   = WORD_BITS / 8,
    localparam int WOFF = $clog2(WB),
    localparam int NW   = LINE_BITS / WORD_BITS,
    localparam int IW   = OFF - WOFF
) (
    input  logic                      write,
    input  logic [ADDR_WIDTH-1:0]     addr,
    input  logic [WORD_BITS-1:0]      wdata,
    input  logic [WB-1:0]             wmask,
    output logic [ADDR_WIDTH-OFF-1:0] line,
    output logic [LB-1:0]             bmask,
    output logic [LINE_BITS-1:0]      bdata
);
    logic [IW-1:0] widx;

    assign line = addr[ADDR_WIDTH-1:OFF];
    assign widx = addr[OFF-1:WOFF];

    // Store word is replicated across the line; only the addressed word's lanes are enabled.
    always_comb begin
        bmask = '0;
        bdata = '0;
        for (int w = 0; w < NW; w++) begin
            bdata[w*WORD_BITS +: WORD_BITS] = wdata;
            if (write && int'(widx) == w) bmask[w*WB +: WB] = wmask;
        end
    end

    if (WOFF > 0) begin : g_lsb
        logic unused_lsb;
        assign unused_lsb = ^addr[WOFF-1:0];
    end
endmodule

module mpnc_mshr_file #(
    parameter int NUM_PORTS   = 2,
    parameter int NUM_ENTRIES = 4,
    parameter int ADDR_WIDTH  = 16,
    parameter int LINE_BITS   = 256,
    parameter int WORD_BITS   = 16
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_PORTS-1:0]                miss_valid,
    input  logic [NUM_PORTS-1:0]                miss_write,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]     miss_addr,
    input  logic [NUM_PORTS*WORD_BITS-1:0]      miss_wdata,
    input  logic [NUM_PORTS*(WORD_BITS/8)-1:0]  miss_wmask,
    output logic [NUM_PORTS-1:0]                miss_ack,
    output logic                                pmem_read,
    output logic [ADDR_WIDTH-1:0]               pmem_address,
    input  logic                                pmem_resp,
    input  logic [LINE_BITS-1:0]                pmem_rdata,
    output logic                                fill_valid,
    output logic [ADDR_WIDTH-1:0]               fill_address,
    output logic [LINE_BITS-1:0]                fill_data,
    output logic                                fill_dirty,
    input  logic                                fill_ack,
    output logic                                mshr_full,
    output logic [$clog2(NUM_ENTRIES+1)-1:0]    mshr_count
);
    localparam int LB  = LINE_BITS / 8;
    localparam int OFF = $clog2(LB);
    localparam int WB  = WORD_BITS / 8;
    localparam int LA  = ADDR_WIDTH - OFF;
    localparam int EW  = $clog2(NUM_ENTRIES);
    localparam int CW  = $clog2(NUM_ENTRIES + 1);

    typedef enum logic [1:0] {FREE, PENDING, ISSUED, FILLED} e_state_t;

    e_state_t                             st   [NUM_ENTRIES];
    e_state_t                             st_n [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0][LA-1:0]        line_q, line_n;
    logic [NUM_ENTRIES-1:0][LB-1:0]        mask_q, mask_n;
    logic [NUM_ENTRIES-1:0][LINE_BITS-1:0] data_q, data_n;
    logic [EW-1:0]                         head, issue, tail, head_n, issue_n, tail_n;
    logic [CW-1:0]                         count_n;
    logic                                  rd_n, do_free;
    logic [ADDR_WIDTH-1:0]                 addr_n;
    logic                                  fv_n, fdirty_n;
    logic [ADDR_WIDTH-1:0]                 faddr_n;
    logic [LINE_BITS-1:0]                  fdata_n;

    logic [NUM_PORTS-1:0][LA-1:0]          p_line;
    logic [NUM_PORTS-1:0][LB-1:0]          p_mask;
    logic [NUM_PORTS-1:0][LINE_BITS-1:0]   p_data;
    logic [NUM_PORTS-1:0]                  alloc;
    logic [NUM_PORTS-1:0][EW-1:0]          tgt;
    logic                                  hit_live, hit_fill;
    logic [EW-1:0]                         hit_idx;
    int                                    n_alloc;

    function automatic logic [EW-1:0] ptr_add(input logic [EW-1:0] p, input int k);
        int s;
        s = (int'(p) + k) % NUM_ENTRIES;
        return EW'(s);
    endfunction

    for (genvar gp = 0; gp < NUM_PORTS; gp++) begin : g_port
        mpnc_mshr_port_dec #(
            .ADDR_WIDTH(ADDR_WIDTH), .LINE_BITS(LINE_BITS), .WORD_BITS(WORD_BITS)
        ) u_dec (
            .write (miss_write[gp]),
            .addr  (miss_addr[gp*ADDR_WIDTH +: ADDR_WIDTH]),
            .wdata (miss_wdata[gp*WORD_BITS +: WORD_BITS]),
            .wmask (miss_wmask[gp*WB +: WB]),
            .line  (p_line[gp]),
            .bmask (p_mask[gp]),
            .bdata (p_data[gp])
        );
    end

    // Acceptance: ports resolved in index order; lower-port allocations are visible to higher ports.
    always_comb begin
        miss_ack = '0;
        alloc    = '0;
        tgt      = '0;
        n_alloc  = 0;
        hit_live = 1'b0;
        hit_fill = 1'b0;
        hit_idx  = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            hit_live = 1'b0;
            hit_fill = 1'b0;
            hit_idx  = '0;
            for (int e = 0; e < NUM_ENTRIES; e++) begin
                if (line_q[e] == p_line[p]) begin
                    if (st[e] == PENDING || st[e] == ISSUED) begin
                        hit_live = 1'b1;
                        hit_idx  = EW'(e);
                    end
                    if (st[e] == FILLED) hit_fill = 1'b1;
                end
            end
            for (int q = 0; q < p; q++) begin
                if (alloc[q] && p_line[q] == p_line[p]) begin
                    hit_live = 1'b1;
                    hit_idx  = tgt[q];
                end
            end
            if (miss_valid[p] && !hit_fill) begin
                if (hit_live) begin
                    miss_ack[p] = 1'b1;
                    tgt[p]      = hit_idx;
                end else if (int'(mshr_count) + n_alloc < NUM_ENTRIES) begin
                    miss_ack[p] = 1'b1;
                    alloc[p]    = 1'b1;
                    tgt[p]      = ptr_add(tail, n_alloc);
                    n_alloc     = n_alloc + 1;
                end
            end
        end
    end

    always_comb begin
        st_n     = st;
        line_n   = line_q;
        mask_n   = mask_q;
        data_n   = data_q;
        head_n   = head;
        issue_n  = issue;
        tail_n   = ptr_add(tail, n_alloc);
        rd_n     = pmem_read;
        addr_n   = pmem_address;
        do_free  = fill_valid && fill_ack;
        fv_n     = 1'b0;
        faddr_n  = fill_address;
        fdata_n  = fill_data;
        fdirty_n = fill_dirty;

        if (do_free) begin
            st_n[head] = FREE;
            head_n     = ptr_add(head, 1);
        end

        for (int p = 0; p < NUM_PORTS; p++) begin
            if (miss_ack[p]) begin
                if (alloc[p]) begin
                    st_n[tgt[p]]   = PENDING;
                    line_n[tgt[p]] = p_line[p];
                    mask_n[tgt[p]] = '0;
                end
                for (int b = 0; b < LB; b++) begin
                    if (p_mask[p][b]) begin
                        mask_n[tgt[p]][b]       = 1'b1;
                        data_n[tgt[p]][b*8 +: 8] = p_data[p][b*8 +: 8];
                    end
                end
            end
        end

        // Returned line fills only bytes no store has claimed, including stores merged this cycle.
        if (pmem_read && pmem_resp) begin
            rd_n        = 1'b0;
            st_n[issue] = FILLED;
            for (int b = 0; b < LB; b++) begin
                if (!mask_n[issue][b]) data_n[issue][b*8 +: 8] = pmem_rdata[b*8 +: 8];
            end
            issue_n = ptr_add(issue, 1);
        end else if (!pmem_read && st_n[issue] == PENDING) begin
            rd_n        = 1'b1;
            st_n[issue] = ISSUED;
            addr_n      = {line_n[issue], {OFF{1'b0}}};
        end

        count_n = mshr_count + CW'(n_alloc) - CW'(do_free);

        if (st_n[head_n] == FILLED) begin
            fv_n     = 1'b1;
            faddr_n  = {line_n[head_n], {OFF{1'b0}}};
            fdata_n  = data_n[head_n];
            fdirty_n = |mask_n[head_n];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int e = 0; e < NUM_ENTRIES; e++) st[e] <= FREE;
            line_q       <= '0;
            mask_q       <= '0;
            data_q       <= '0;
            head         <= '0;
            issue        <= '0;
            tail         <= '0;
            mshr_count   <= '0;
            pmem_read    <= 1'b0;
            pmem_address <= '0;
            fill_valid   <= 1'b0;
            fill_address <= '0;
            fill_data    <= '0;
            fill_dirty   <= 1'b0;
        end else begin
            st           <= st_n;
            line_q       <= line_n;
            mask_q       <= mask_n;
            data_q       <= data_n;
            head         <= head_n;
            issue        <= issue_n;
            tail         <= tail_n;
            mshr_count   <= count_n;
            pmem_read    <= rd_n;
            pmem_address <= addr_n;
            fill_valid   <= fv_n;
            fill_address <= faddr_n;
            fill_data    <= fdata_n;
            fill_dirty   <= fdirty_n;
        end
    end

    assign mshr_full = (mshr_count == CW'(NUM_ENTRIES));
endmodule
